// File: rtl/sd_cmd_card_phys.sv
// Card-side SD CMD line PHY: receives 48-bit host commands with CRC7/framing checks and
// serializes 48-bit or 136-bit responses after the Ncr gap, generating the CRC7 on the fly.
module sd_cmd_card_phys #(
    parameter int unsigned NCR   = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_strobe,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_crc_err,
    output logic         cmd_frame_err,
    input  logic         cmd_ack,
    input  logic         no_rsp,
    input  logic         rsp_strobe,
    input  logic         rsp_long,
    input  logic [135:0] rsp_data,
    output logic         rsp_ack,
    output logic         rsp_done,
    input  logic         idle_in
);

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StCmdHold,
        StWaitRsp,
        StGap,
        StTx
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [46:0]        r_rx;
    logic [6:0]         r_crc;
    logic [135:0]       r_tx;
    logic               r_long;
    logic [5:0]         r_cmd_index;
    logic [31:0]        r_cmd_arg;
    logic               r_crc_err;
    logic               r_frame_err;
    logic               r_rsp_ack;
    logic               r_rsp_done;
    logic [47:0]        w_frame;
    logic               w_unused;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Full received frame as seen on the edge that samples the end bit.
    assign w_frame  = {r_rx, cmd_in};
    assign w_unused = ^{rsp_data[135:128], w_frame[47]};

    assign cmd_index     = r_cmd_index;
    assign cmd_arg       = r_cmd_arg;
    assign cmd_crc_err   = r_crc_err;
    assign cmd_frame_err = r_frame_err;
    assign rsp_ack       = r_rsp_ack;
    assign rsp_done      = r_rsp_done;

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_out     = 1'b1;
        cmd_oe      = 1'b0;
        cmd_strobe  = 1'b0;
        case (r_state)
            StIdle: begin
                if (!cmd_in) w_state_nxt = StRx;
            end
            StRx: begin
                if (r_cnt == '0) w_state_nxt = StCmdHold;
            end
            StCmdHold: begin
                cmd_strobe = 1'b1;
                if (cmd_ack) w_state_nxt = no_rsp ? StIdle : StWaitRsp;
            end
            StWaitRsp: begin
                if (rsp_strobe) w_state_nxt = StGap;
            end
            StGap: begin
                if (r_cnt == '0) w_state_nxt = StTx;
            end
            StTx: begin
                cmd_oe = 1'b1;
                if (r_cnt >= CNT_W'(8)) begin
                    cmd_out = r_tx[135];
                end else if (r_cnt != '0) begin
                    cmd_out = r_crc[6];
                end
                if (r_cnt == '0) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
        if (idle_in) w_state_nxt = StIdle;
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_rx        <= '0;
            r_crc       <= '0;
            r_tx        <= '0;
            r_long      <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_arg   <= '0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rsp_ack   <= 1'b0;
            r_rsp_done  <= 1'b0;
        end else begin
            r_rsp_ack  <= 1'b0;
            r_rsp_done <= 1'b0;
            if (!idle_in) begin
                case (r_state)
                    StIdle: begin
                        // Start bit (0) is already bit 47 of the frame; CRC of a lone 0 is 0.
                        if (!cmd_in) begin
                            r_cnt <= CNT_W'(46);
                            r_rx  <= '0;
                            r_crc <= '0;
                        end
                    end
                    StRx: begin
                        r_rx <= {r_rx[45:0], cmd_in};
                        if (r_cnt >= CNT_W'(8)) r_crc <= crc7_step(r_crc, cmd_in);
                        if (r_cnt == '0) begin
                            r_cmd_index <= w_frame[45:40];
                            r_cmd_arg   <= w_frame[39:8];
                            r_crc_err   <= (w_frame[7:1] != r_crc);
                            r_frame_err <= !w_frame[46] || !w_frame[0];
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    StWaitRsp: begin
                        if (rsp_strobe) begin
                            r_rsp_ack <= 1'b1;
                            r_long    <= rsp_long;
                            r_cnt     <= CNT_W'(NCR - 1);
                            if (rsp_long) begin
                                r_tx <= {8'h3F, rsp_data[127:0]};
                            end else begin
                                r_tx <= {2'b00, rsp_data[45:0], 88'd0};
                            end
                        end
                    end
                    StGap: begin
                        if (r_cnt == '0) begin
                            r_cnt <= r_long ? CNT_W'(135) : CNT_W'(47);
                            r_crc <= '0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    StTx: begin
                        r_tx <= {r_tx[134:0], 1'b0};
                        if (r_cnt >= CNT_W'(8)) begin
                            // R2 header byte is excluded from the CRC.
                            if (!(r_long && r_cnt >= CNT_W'(128))) begin
                                r_crc <= crc7_step(r_crc, r_tx[135]);
                            end
                        end else begin
                            r_crc <= {r_crc[5:0], 1'b0};
                        end
                        if (r_cnt == '0) begin
                            r_rsp_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
